apb_downsizer_n: RTL and testbench
==================================

# apb_downsizer_n

Parametrised APB width converter: accepts one wide APB transfer on its upstream (completer) port and issues it as a sequence of narrow APB transfers on its downstream (requester) port, one beat per narrow data lane. It sits between the wide system APB fabric and narrow peripherals of the crypto accelerator. It adds configurable width ratio, error propagation with beat abort and optional zero-strobe beat skipping.

## Interface
- ADDR_W, 32, address width, both ports
- DATA_W_IN, 32, upstream data width; equals DATA_W_OUT * N, where N is a power of two and N >= 2
- DATA_W_OUT, 16, downstream data width; a multiple of 8 and at least 8
- Derived values: N = DATA_W_IN/DATA_W_OUT; IB = DATA_W_IN/8; OB = DATA_W_OUT/8

Ports:
- pclk  in  1  clock; all logic on the rising edge
- preset_n  in  1  reset; synchronous, active-low
- psel_i, penable_i, pwrite_i  in  1 each  upstream APB control
- paddr_i  in  ADDR_W  upstream address
- pwdata_i  in  DATA_W_IN  upstream write data
- pstrb_i  in  IB  upstream byte strobes; used on reads as well as writes
- prdata_o  out  DATA_W_IN  upstream read data
- pready_o, pslverr_o  out  1 each  upstream completion and error
- psel_o, penable_o, pwrite_o  out  1 each  downstream APB control
- paddr_o  out  ADDR_W  downstream address
- pwdata_o  out  DATA_W_OUT  downstream write data
- pstrb_o  out  OB  downstream byte strobes
- prdata_i  in  DATA_W_OUT  downstream read data
- pready_i, pslverr_i  in  1 each  downstream completion and error

## Operation
- FSM states:
  - IDLE
  - SETUP: downstream psel_o=1, penable_o=0
  - ACCESS: psel_o=1, penable_o=1
  - DONE: pready_o=1 for exactly one cycle
- IDLE -> SETUP when psel_i & penable_i are both high.
- On that transition, latch these into registers: paddr_i, pwrite_i, pwdata_i, pstrb_i. Clear prdata_o and the error flag.
- The beat index k runs from 0 to N-1, in ascending order.
- Beat k drives:
  - paddr_o = (paddr_i & ~(IB-1)) + k*OB
  - pwdata_o = pwdata_i[k*DATA_W_OUT +: DATA_W_OUT]
  - pstrb_o = pstrb_i[k*OB +: OB]
  - pwrite_o = the latched pwrite_i
- Each beat always passes SETUP -> ACCESS.
- ACCESS is held while pready_i=0.
- When pready_i=1 in ACCESS:
  - On a read, capture prdata_i into prdata_o lane k.
  - Then go to SETUP of the next issued beat, or to DONE after the last beat.
- If pslverr_i=1 with pready_i=1, set the error flag and go to DONE. The remaining beats are not issued.
- DONE -> IDLE unconditionally. pslverr_o equals the error flag while in DONE and is 0 otherwise.
- Read lanes that are never transferred return 0 in prdata_o.
- Upstream psel_i/penable_i dropping mid-conversion is a protocol violation. It is ignored: downstream beats run to completion and are never left hanging.
- prdata_o holds its value from DONE until the next transfer starts.
- Reset (preset_n=0 at an edge), including mid-beat:
  - The FSM goes to IDLE.
  - Every output is 0 after that edge: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, prdata_o, pready_o, pslverr_o.
  - The downstream transfer in progress is abandoned.

## Timing
- All outputs are registered.
- Latency from the upstream access being seen in IDLE:
  - First SETUP is on the next cycle.
  - Minimum per beat is 2 cycles (pready_i=1 in the first ACCESS cycle).
  - DONE is the cycle after the last ACCESS that completes.
- N=2, full strobe, zero wait states: IDLE(c0), SETUP0(c1), ACCESS0(c2), SETUP1(c3), ACCESS1(c4), DONE(c5). pready_o is high in c5 only.
- Each downstream wait state adds exactly one cycle.
- An upstream pready_o pulse never occurs outside DONE.
- A new upstream access cannot be accepted in DONE; it is accepted at the earliest in the IDLE cycle that follows.

## Configuration
- APB_DOWNSIZER_SKIP_EN defined:
  - Beats whose strobe slice is all-zero are not issued, for both reads and writes.
  - If every beat is skipped (pstrb_i = 0), the FSM goes IDLE -> DONE, completing in 2 cycles. The result is pready_o=1, pslverr_o=0 and, on a read, prdata_o=0.
- APB_DOWNSIZER_SKIP_EN undefined:
  - All N beats are always issued, including beats with pstrb_o = 0.
  - pstrb_i = 0 still produces N beats.

## Test plan
- Write with the defaults (strobe test, no wait states): paddr_i=0x600, pwdata_i=0x77554433, pstrb_i=0x6 -> beat0 paddr_o=0x600, pwdata_o=0x4433, pstrb_o=2'b10; beat1 paddr_o=0x602, pwdata_o=0x7755, pstrb_o=2'b01; one pready_o pulse; pslverr_o=0.
- Read with wait states: paddr_i=0x3334, pstrb_i=0xF, prdata_i=0xCC33 on beat0 and then 0x1111 on beat1, pready_i delayed 5 cycles on beat0 -> beats at 0x3334 and 0x3336; prdata_o=0x1111CC33 in DONE; DONE arrives 5 cycles later than the zero-wait case.
- Skip mode: write paddr_i=0x8, pwdata_i=0xBBAAFF00, pstrb_i=0xC.
  - SKIP_EN defined -> one beat: paddr_o=0xA, pwdata_o=0xBBAA, pstrb_o=2'b11.
  - SKIP_EN undefined -> two beats, beat0 pstrb_o=2'b00.
  - Both builds: pstrb_i=0 (SKIP_EN defined gives pready_o 2 cycles after the access).
- Error abort: on a read of 0x1C, pslverr_i=1 with pready_i=1 on beat0 -> no beat1 issued; pready_o=1 and pslverr_o=1 in the same cycle; prdata_o=0; the next transfer shows pslverr_o=0.
- Reset mid-beat: assert preset_n=0 during ACCESS of beat1 -> all outputs are 0 after the edge; the next upstream access starts again at beat0.
- Wide config DATA_W_IN=64, DATA_W_OUT=16: write paddr_i=0x10, pwdata_i=0x0123456789ABCDEF, pstrb_i=0xFF -> four beats at 0x10, 0x12, 0x14, 0x16 with pwdata_o 0xCDEF, 0x89AB, 0x4567, 0x0123.

Source files
------------

// File: rtl/apb_downsizer_n.sv
// APB width converter: one wide upstream transfer becomes N narrow downstream beats.
// Optional zero-strobe beat skipping is enabled by defining APB_DOWNSIZER_SKIP_EN.
module apb_downsizer_n #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W_IN  = 32,
  parameter int DATA_W_OUT = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_W-1:0]       paddr_i,
  input  logic [DATA_W_IN-1:0]    pwdata_i,
  input  logic [DATA_W_IN/8-1:0]  pstrb_i,
  output logic [DATA_W_IN-1:0]    prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_W-1:0]       paddr_o,
  output logic [DATA_W_OUT-1:0]   pwdata_o,
  output logic [DATA_W_OUT/8-1:0] pstrb_o,
  input  logic [DATA_W_OUT-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int N  = DATA_W_IN / DATA_W_OUT;
  localparam int IB = DATA_W_IN / 8;
  localparam int OB = DATA_W_OUT / 8;
  localparam int BW = $clog2(N);

`ifdef APB_DOWNSIZER_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic                   write_q, write_d;
  logic [DATA_W_IN-1:0]   wdata_q, wdata_d;
  logic [IB-1:0]          strb_q, strb_d;
  logic [DATA_W_IN-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]      paddr_q, paddr_d;
  logic [DATA_W_OUT-1:0]  pwdata_q, pwdata_d;
  logic [OB-1:0]          pstrb_q, pstrb_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;

  logic [BW:0]            nxt;
  logic                   active;

  // Lowest beat index >= from that must be issued; N means no beat is left.
  function automatic logic [BW:0] first_beat(input logic [IB-1:0] strb, input logic [BW:0] from);
    logic [BW:0] res;
    logic        live;
    res = (BW+1)'(N);
    for (int i = N-1; i >= 0; i--) begin
      live = (strb[i*OB +: OB] != '0) || !SKIP_EN;
      if (((BW+1)'(i) >= from) && live) begin
        res = (BW+1)'(i);
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    nxt     = '0;

    case (state_q)
      IDLE: begin
        if (psel_i && penable_i) begin
          base_d  = paddr_i & ~ADDR_W'(IB-1);
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          rdata_d = '0;
          err_d   = 1'b0;
          nxt     = first_beat(pstrb_i, '0);
          if (nxt == (BW+1)'(N)) begin
            state_d = DONE;
          end else begin
            beat_d  = nxt[BW-1:0];
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          // An error aborts the remaining beats and leaves the read lane uncaptured.
          if (pslverr_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            if (!write_q) begin
              rdata_d[beat_q*DATA_W_OUT +: DATA_W_OUT] = prdata_i;
            end
            nxt = first_beat(strb_q, {1'b0, beat_q} + (BW+1)'(1));
            if (nxt == (BW+1)'(N)) begin
              state_d = DONE;
            end else begin
              beat_d  = nxt[BW-1:0];
              state_d = SETUP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that every port comes from a flop.
  always_comb begin
    active    = (state_d == SETUP) || (state_d == ACCESS);
    psel_d    = active;
    penable_d = (state_d == ACCESS);
    pwrite_d  = active && write_d;
    paddr_d   = '0;
    pwdata_d  = '0;
    pstrb_d   = '0;
    if (active) begin
      paddr_d  = base_d + (ADDR_W'(beat_d) * ADDR_W'(OB));
      pwdata_d = wdata_d[beat_d*DATA_W_OUT +: DATA_W_OUT];
      pstrb_d  = strb_d[beat_d*OB +: OB];
    end
    pready_d  = (state_d == DONE);
    pslverr_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign prdata_o  = rdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_downsizer_n.sv
// Directed self-checking bench for apb_downsizer_n (32->16 instance plus a 64->16 instance).
module tb_apb_downsizer_n;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic [3:0]  pstrb_i;
  logic        pready_o, pslverr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o;
  logic [15:0] pwdata_o, prdata_i;
  logic [1:0]  pstrb_o;
  logic        pready_i, pslverr_i;

  logic        w_psel_i, w_penable_i, w_pwrite_i;
  logic [31:0] w_paddr_i, w_paddr_o;
  logic [63:0] w_pwdata_i, w_prdata_o;
  logic [7:0]  w_pstrb_i;
  logic        w_pready_o, w_pslverr_o, w_psel_o, w_penable_o, w_pwrite_o;
  logic [15:0] w_pwdata_o, w_prdata_i;
  logic [1:0]  w_pstrb_o;
  logic        w_pready_i, w_pslverr_i;

  int checks = 0;
  int errors = 0;

  int          waits[8];
  logic [15:0] rd[8];
  int          err_beat;
  int          nbeats, cycles;
  logic [31:0] b_addr[8];
  logic [15:0] b_wdata[8];
  logic [1:0]  b_strb[8];
  logic        b_write[8];
  logic [31:0] res_rdata, post_rdata;
  logic        res_err, post_pready, post_err;

  always #5 pclk = ~pclk;

  apb_downsizer_n #(.ADDR_W(32), .DATA_W_IN(32), .DATA_W_OUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  apb_downsizer_n #(.ADDR_W(32), .DATA_W_IN(64), .DATA_W_OUT(16)) dut_wide (
    .pclk(pclk), .preset_n(preset_n),
    .psel_i(w_psel_i), .penable_i(w_penable_i), .pwrite_i(w_pwrite_i),
    .paddr_i(w_paddr_i), .pwdata_i(w_pwdata_i), .pstrb_i(w_pstrb_i),
    .prdata_o(w_prdata_o), .pready_o(w_pready_o), .pslverr_o(w_pslverr_o),
    .psel_o(w_psel_o), .penable_o(w_penable_o), .pwrite_o(w_pwrite_o),
    .paddr_o(w_paddr_o), .pwdata_o(w_pwdata_o), .pstrb_o(w_pstrb_o),
    .prdata_i(w_prdata_i), .pready_i(w_pready_i), .pslverr_i(w_pslverr_i)
  );

  task automatic clear_cfg();
    for (int i = 0; i < 8; i++) begin
      waits[i] = 0;
      rd[i]    = 16'h0;
    end
    err_beat = -1;
  endtask

  // Upstream requester plus downstream responder, stepped on the falling edge.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st);
    int  cnt;
    bit  done;
    nbeats = 0; cycles = 0; cnt = 0; done = 0;
    @(negedge pclk);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = st;
    @(negedge pclk);
    penable_i = 1'b1;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge pclk);
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 16'h0;
      if (psel_o && penable_o && nbeats < 8) begin
        if (cnt < waits[nbeats]) begin
          cnt++;
        end else begin
          pready_i  = 1'b1;
          prdata_i  = rd[nbeats];
          pslverr_i = (nbeats == err_beat);
          b_addr[nbeats]  = paddr_o;
          b_wdata[nbeats] = pwdata_o;
          b_strb[nbeats]  = pstrb_o;
          b_write[nbeats] = pwrite_o;
          nbeats++;
          cnt = 0;
        end
      end
      if (pready_o) begin
        done = 1; cycles = c; res_rdata = prdata_o; res_err = pslverr_o;
        psel_i = 1'b0; penable_i = 1'b0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL xfer_timeout: got no pready_o, expected pready_o within 200 cycles");
      psel_i = 1'b0; penable_i = 1'b0;
    end
    @(negedge pclk);
    pready_i = 1'b0; pslverr_i = 1'b0;
    post_pready = pready_o; post_err = pslverr_o; post_rdata = prdata_o;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, prdata_o, pready_o, pslverr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got psel=%b paddr=%h prdata=%h pready=%b, expected all 0",
               psel_o, paddr_o, prdata_o, pready_o);
    end
    checks++;
    if ({w_psel_o, w_penable_o, w_pwrite_o, w_paddr_o, w_pwdata_o, w_pstrb_o, w_prdata_o, w_pready_o, w_pslverr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_wide: got psel=%b paddr=%h, expected all 0", w_psel_o, w_paddr_o);
    end
  endtask

  task automatic test_write_strobe();
    clear_cfg();
    run_xfer(32'h600, 1'b1, 32'h77554433, 4'h6);
    checks++; if (nbeats !== 2) begin errors++; $display("[TB] FAIL ws_nbeats: got %0d expected 2", nbeats); end
    checks++; if (b_addr[0] !== 32'h600) begin errors++; $display("[TB] FAIL ws_addr0: got %h expected 00000600", b_addr[0]); end
    checks++; if (b_wdata[0] !== 16'h4433) begin errors++; $display("[TB] FAIL ws_wdata0: got %h expected 4433", b_wdata[0]); end
    checks++; if (b_strb[0] !== 2'b10) begin errors++; $display("[TB] FAIL ws_strb0: got %b expected 10", b_strb[0]); end
    checks++; if (b_addr[1] !== 32'h602) begin errors++; $display("[TB] FAIL ws_addr1: got %h expected 00000602", b_addr[1]); end
    checks++; if (b_wdata[1] !== 16'h7755) begin errors++; $display("[TB] FAIL ws_wdata1: got %h expected 7755", b_wdata[1]); end
    checks++; if (b_strb[1] !== 2'b01) begin errors++; $display("[TB] FAIL ws_strb1: got %b expected 01", b_strb[1]); end
    checks++; if ({b_write[0], b_write[1]} !== 2'b11) begin errors++; $display("[TB] FAIL ws_pwrite: got %b%b expected 11", b_write[0], b_write[1]); end
    checks++; if (cycles !== 5) begin errors++; $display("[TB] FAIL ws_latency: got %0d expected 5", cycles); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL ws_pslverr: got %b expected 0", res_err); end
    checks++; if (post_pready !== 1'b0) begin errors++; $display("[TB] FAIL ws_pready_single: got %b expected 0", post_pready); end
  endtask

  task automatic test_read_wait();
    clear_cfg();
    waits[0] = 5; rd[0] = 16'hCC33; rd[1] = 16'h1111;
    run_xfer(32'h3334, 1'b0, 32'h0, 4'hF);
    checks++; if (nbeats !== 2) begin errors++; $display("[TB] FAIL rw_nbeats: got %0d expected 2", nbeats); end
    checks++; if (b_addr[0] !== 32'h3334) begin errors++; $display("[TB] FAIL rw_addr0: got %h expected 00003334", b_addr[0]); end
    checks++; if (b_addr[1] !== 32'h3336) begin errors++; $display("[TB] FAIL rw_addr1: got %h expected 00003336", b_addr[1]); end
    checks++; if ({b_write[0], b_write[1]} !== 2'b00) begin errors++; $display("[TB] FAIL rw_pwrite: got %b%b expected 00", b_write[0], b_write[1]); end
    checks++; if (res_rdata !== 32'h1111CC33) begin errors++; $display("[TB] FAIL rw_prdata: got %h expected 1111cc33", res_rdata); end
    checks++; if (cycles !== 10) begin errors++; $display("[TB] FAIL rw_latency: got %0d expected 10", cycles); end
    checks++; if (post_rdata !== 32'h1111CC33) begin errors++; $display("[TB] FAIL rw_prdata_hold: got %h expected 1111cc33", post_rdata); end
  endtask

  task automatic test_error_abort();
    clear_cfg();
    err_beat = 0; rd[0] = 16'hDEAD; rd[1] = 16'hBEEF;
    run_xfer(32'h1C, 1'b0, 32'h0, 4'hF);
    checks++; if (nbeats !== 1) begin errors++; $display("[TB] FAIL err_nbeats: got %0d expected 1", nbeats); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL err_pslverr: got %b expected 1", res_err); end
    checks++; if (res_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err_prdata: got %h expected 00000000", res_rdata); end
    checks++; if (cycles !== 3) begin errors++; $display("[TB] FAIL err_latency: got %0d expected 3", cycles); end
    checks++; if (post_err !== 1'b0) begin errors++; $display("[TB] FAIL err_pslverr_after: got %b expected 0", post_err); end
    clear_cfg();
    rd[0] = 16'h2222; rd[1] = 16'h3333;
    run_xfer(32'h20, 1'b0, 32'h0, 4'hF);
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL err_next_pslverr: got %b expected 0", res_err); end
    checks++; if (res_rdata !== 32'h33332222) begin errors++; $display("[TB] FAIL err_next_prdata: got %h expected 33332222", res_rdata); end
  endtask

  task automatic test_skip();
    clear_cfg();
    run_xfer(32'h8, 1'b1, 32'hBBAAFF00, 4'hC);
`ifdef APB_DOWNSIZER_SKIP_EN
    checks++; if (nbeats !== 1) begin errors++; $display("[TB] FAIL skip_nbeats: got %0d expected 1", nbeats); end
    checks++; if (b_addr[0] !== 32'hA) begin errors++; $display("[TB] FAIL skip_addr: got %h expected 0000000a", b_addr[0]); end
    checks++; if (b_wdata[0] !== 16'hBBAA) begin errors++; $display("[TB] FAIL skip_wdata: got %h expected bbaa", b_wdata[0]); end
    checks++; if (b_strb[0] !== 2'b11) begin errors++; $display("[TB] FAIL skip_strb: got %b expected 11", b_strb[0]); end
`else
    checks++; if (nbeats !== 2) begin errors++; $display("[TB] FAIL noskip_nbeats: got %0d expected 2", nbeats); end
    checks++; if (b_strb[0] !== 2'b00) begin errors++; $display("[TB] FAIL noskip_strb0: got %b expected 00", b_strb[0]); end
    checks++; if (b_wdata[0] !== 16'hFF00) begin errors++; $display("[TB] FAIL noskip_wdata0: got %h expected ff00", b_wdata[0]); end
    checks++; if (b_addr[1] !== 32'hA) begin errors++; $display("[TB] FAIL noskip_addr1: got %h expected 0000000a", b_addr[1]); end
    checks++; if (b_strb[1] !== 2'b11) begin errors++; $display("[TB] FAIL noskip_strb1: got %b expected 11", b_strb[1]); end
`endif
    clear_cfg();
    rd[0] = 16'h5555; rd[1] = 16'h6666;
    run_xfer(32'h44, 1'b0, 32'h0, 4'h0);
`ifdef APB_DOWNSIZER_SKIP_EN
    checks++; if (nbeats !== 0) begin errors++; $display("[TB] FAIL skipall_nbeats: got %0d expected 0", nbeats); end
    checks++; if (cycles !== 1) begin errors++; $display("[TB] FAIL skipall_latency: got %0d expected 1", cycles); end
    checks++; if (res_rdata !== 32'h0) begin errors++; $display("[TB] FAIL skipall_prdata: got %h expected 00000000", res_rdata); end
`else
    checks++; if (nbeats !== 2) begin errors++; $display("[TB] FAIL zerostrb_nbeats: got %0d expected 2", nbeats); end
    checks++; if (cycles !== 5) begin errors++; $display("[TB] FAIL zerostrb_latency: got %0d expected 5", cycles); end
    checks++; if (b_strb[1] !== 2'b00) begin errors++; $display("[TB] FAIL zerostrb_strb1: got %b expected 00", b_strb[1]); end
    checks++; if (res_rdata !== 32'h66665555) begin errors++; $display("[TB] FAIL zerostrb_prdata: got %h expected 66665555", res_rdata); end
`endif
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL zerostrb_pslverr: got %b expected 0", res_err); end
  endtask

  task automatic test_reset_mid_beat();
    bit hit;
    hit = 0;
    clear_cfg();
    @(negedge pclk);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h40; pwrite_i = 1'b1; pwdata_i = 32'h12345678; pstrb_i = 4'hF;
    @(negedge pclk);
    penable_i = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge pclk);
      pready_i = 1'b0;
      if (psel_o && penable_o && paddr_o == 32'h42) hit = 1;
      else if (psel_o && penable_o) pready_i = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL rst_reach_beat1: got no beat1 ACCESS, expected one within 40 cycles"); end
    preset_n = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, prdata_o, pready_o, pslverr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got psel=%b penable=%b paddr=%h pwdata=%h, expected all 0",
               psel_o, penable_o, paddr_o, pwdata_o);
    end
    preset_n = 1'b1;
    clear_cfg();
    run_xfer(32'h80, 1'b1, 32'hA5A55A5A, 4'hF);
    checks++; if (nbeats !== 2) begin errors++; $display("[TB] FAIL rst_next_nbeats: got %0d expected 2", nbeats); end
    checks++; if (b_addr[0] !== 32'h80) begin errors++; $display("[TB] FAIL rst_next_addr0: got %h expected 00000080", b_addr[0]); end
    checks++; if (b_wdata[0] !== 16'h5A5A) begin errors++; $display("[TB] FAIL rst_next_wdata0: got %h expected 5a5a", b_wdata[0]); end
  endtask

  task automatic test_wide();
    logic [31:0] wa[4];
    logic [15:0] wd[4];
    int          wn, wc;
    bit          done;
    wn = 0; wc = 0; done = 0;
    @(negedge pclk);
    w_psel_i = 1'b1; w_penable_i = 1'b0; w_paddr_i = 32'h10; w_pwrite_i = 1'b1;
    w_pwdata_i = 64'h0123456789ABCDEF; w_pstrb_i = 8'hFF;
    @(negedge pclk);
    w_penable_i = 1'b1;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge pclk);
      if (w_psel_o && w_penable_o && wn < 4) begin
        wa[wn] = w_paddr_o; wd[wn] = w_pwdata_o; wn++;
      end
      if (w_pready_o) begin
        done = 1; wc = c; w_psel_i = 1'b0; w_penable_i = 1'b0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL wide_timeout: got no pready_o, expected pready_o within 100 cycles"); w_psel_i = 1'b0; w_penable_i = 1'b0; end
    checks++; if (wn !== 4) begin errors++; $display("[TB] FAIL wide_nbeats: got %0d expected 4", wn); end
    checks++; if (wc !== 9) begin errors++; $display("[TB] FAIL wide_latency: got %0d expected 9", wc); end
    if (wn == 4) begin
      checks++; if ({wa[0], wa[1], wa[2], wa[3]} !== {32'h10, 32'h12, 32'h14, 32'h16}) begin
        errors++; $display("[TB] FAIL wide_addr: got %h %h %h %h expected 10 12 14 16", wa[0], wa[1], wa[2], wa[3]);
      end
      checks++; if ({wd[0], wd[1], wd[2], wd[3]} !== {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123}) begin
        errors++; $display("[TB] FAIL wide_wdata: got %h %h %h %h expected cdef 89ab 4567 0123", wd[0], wd[1], wd[2], wd[3]);
      end
    end
  endtask

  initial begin
    preset_n = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    w_psel_i = 1'b0; w_penable_i = 1'b0; w_pwrite_i = 1'b0; w_paddr_i = '0; w_pwdata_i = '0; w_pstrb_i = '0;
    w_prdata_i = '0; w_pready_i = 1'b1; w_pslverr_i = 1'b0;
    clear_cfg();
    repeat (3) @(negedge pclk);
    test_reset();
    preset_n = 1'b1;
    test_write_strobe();
    test_read_wait();
    test_error_abort();
    test_skip();
    test_reset_mid_beat();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
